// File: rtl/huff_decoder.sv
// ---------------------------------------------------------------------------
// huff_decoder
//
// Serial prefix-code (Huffman) decoder. A code table of up to MAX_CHAR_COUNT
// entries is captured on a tbl_load pulse. Code bits then arrive MSB-first,
// one per accepted cycle. As soon as the accumulated bits form a complete
// code, the matching character is presented on a valid/ready output port.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high
//   tbl_load       : one-cycle pulse, captures the table and starts a stream
//   character      : entry i in bits [8i+7:8i]
//   encoded_value  : code i in bits [N*i +: N], LSB-aligned
//   encoded_mask   : mask i in bits [N*i +: N], contiguous ones from bit 0
//   unique_count   : number of valid table entries
//   bit_in         : serial code bit
//   bit_valid      : bit_in is valid
//   last_bit       : this bit is the final bit of the stream
//   bit_ready      : decoder accepts a bit this cycle (RECV only)
//   char_out       : decoded character
//   char_valid     : char_out is valid
//   char_ready     : downstream accepts char_out
//   char_count     : characters emitted so far (saturating)
//   done           : stream fully decoded (sticky)
//   error          : invalid or truncated code (sticky)
// ---------------------------------------------------------------------------
module huff_decoder #(
  parameter int MAX_CHAR_COUNT    = 4,
  parameter int MAX_STRING_LENGTH = 10
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         tbl_load,
  input  logic [MAX_CHAR_COUNT*8-1:0]                  character,
  input  logic [MAX_CHAR_COUNT*MAX_CHAR_COUNT-1:0]     encoded_value,
  input  logic [MAX_CHAR_COUNT*MAX_CHAR_COUNT-1:0]     encoded_mask,
  input  logic [$clog2(MAX_CHAR_COUNT):0]              unique_count,
  input  logic                                         bit_in,
  input  logic                                         bit_valid,
  input  logic                                         last_bit,
  output logic                                         bit_ready,
  output logic [7:0]                                   char_out,
  output logic                                         char_valid,
  input  logic                                         char_ready,
  output logic [$clog2(MAX_STRING_LENGTH+1)-1:0]       char_count,
  output logic                                         done,
  output logic                                         error
);

  localparam int N   = MAX_CHAR_COUNT;
  localparam int UCW = $clog2(N) + 1;
  localparam int LW  = $clog2(N + 1);
  localparam int CCW = $clog2(MAX_STRING_LENGTH + 1);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [CCW-1:0] COUNT_MAX = CCW'(MAX_STRING_LENGTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    EMIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t           state_q;

  // Captured code table
  logic [N*8-1:0]   char_tbl_q;
  logic [N*N-1:0]   val_tbl_q;
  logic [N*N-1:0]   mask_tbl_q;
  logic [UCW-1:0]   ucnt_q;
  logic [LW-1:0]    max_len_q;

  // Bit accumulator for the code currently being received
  logic [N-1:0]     acc_q;
  logic [LW-1:0]    len_q;

  logic [7:0]       char_out_q;
  logic             char_valid_q;
  logic [CCW-1:0]   char_count_q;
  // Remembers whether the bit that completed the pending character was last
  logic             last_q;

  logic [N-1:0]     acc_d;
  logic [LW-1:0]    len_d;
  logic             hit_d;
  logic [IW-1:0]    hit_idx_d;
  logic [LW-1:0]    max_len_d;

  // Code length is the popcount of its (contiguous) mask.
  function automatic logic [LW-1:0] popcount(input logic [N-1:0] m);
    logic [LW-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < N; b++) begin
      cnt = cnt + LW'(m[b]);
    end
    return cnt;
  endfunction

  always_comb begin
    acc_d     = (acc_q << 1) | N'(bit_in);
    len_d     = len_q + LW'(1);
    hit_d     = 1'b0;
    hit_idx_d = '0;
    max_len_d = '0;

    if (ucnt_q == UCW'(1)) begin
      // A single-symbol alphabet needs no bits to disambiguate: every
      // accepted bit stands for character[0] regardless of its value.
      hit_d = 1'b1;
    end else begin
      // Scan downwards so the lowest matching index is the one left standing.
      for (int i = N - 1; i >= 0; i--) begin
        if ((i < int'(ucnt_q)) &&
            (mask_tbl_q[i*N +: N] != '0) &&
            (popcount(mask_tbl_q[i*N +: N]) == len_d) &&
            ((acc_d & mask_tbl_q[i*N +: N]) ==
             (val_tbl_q[i*N +: N] & mask_tbl_q[i*N +: N]))) begin
          hit_d     = 1'b1;
          hit_idx_d = IW'(i);
        end
      end
    end

    // Longest valid code, computed from the table being loaded.
    for (int i = 0; i < N; i++) begin
      if ((i < int'(unique_count)) &&
          (popcount(encoded_mask[i*N +: N]) > max_len_d)) begin
        max_len_d = popcount(encoded_mask[i*N +: N]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      char_tbl_q   <= '0;
      val_tbl_q    <= '0;
      mask_tbl_q   <= '0;
      ucnt_q       <= '0;
      max_len_q    <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      char_count_q <= '0;
      last_q       <= 1'b0;
    end else if (tbl_load) begin
      char_tbl_q   <= character;
      val_tbl_q    <= encoded_value;
      mask_tbl_q   <= encoded_mask;
      ucnt_q       <= unique_count;
      max_len_q    <= max_len_d;
      acc_q        <= '0;
      len_q        <= '0;
      char_valid_q <= 1'b0;
      char_count_q <= '0;
      last_q       <= 1'b0;
      state_q      <= RECV;
    end else begin
      case (state_q)
        RECV: begin
          if (bit_valid) begin
            if (hit_d) begin
              acc_q <= '0;
              len_q <= '0;
              if (char_count_q == COUNT_MAX) begin
                // No room for another character in this stream.
                state_q <= ERR;
              end else begin
                char_out_q   <= char_tbl_q[hit_idx_d*8 +: 8];
                char_valid_q <= 1'b1;
                last_q       <= last_bit;
                state_q      <= EMIT;
              end
            end else if (last_bit || (len_d >= max_len_q)) begin
              // Either the stream ended mid-code or the code grew past the
              // longest entry; with an empty table max_len is 0 and the
              // first bit lands here.
              state_q <= ERR;
            end else begin
              acc_q <= acc_d;
              len_q <= len_d;
            end
          end
        end
        EMIT: begin
          if (char_ready) begin
            char_valid_q <= 1'b0;
            if (char_count_q < COUNT_MAX) begin
              char_count_q <= char_count_q + CCW'(1);
            end
            state_q <= last_q ? DONE : RECV;
          end
        end
        default: begin
          // IDLE, DONE and ERR hold until tbl_load or reset.
        end
      endcase
    end
  end

  assign bit_ready  = (state_q == RECV);
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign char_count = char_count_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule

// File: tb/tb_huff_decoder.sv
module tb_huff_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tbl_load = 1'b0;
  logic [31:0] character = '0;
  logic [15:0] encoded_value = '0;
  logic [15:0] encoded_mask = '0;
  logic [2:0]  unique_count = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        last_bit = 1'b0;
  logic        bit_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic [3:0]  char_count;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] got_q[$];

  huff_decoder #(.MAX_CHAR_COUNT(4), .MAX_STRING_LENGTH(10)) dut (
    .clk(clk), .reset(reset), .tbl_load(tbl_load), .character(character),
    .encoded_value(encoded_value), .encoded_mask(encoded_mask),
    .unique_count(unique_count), .bit_in(bit_in), .bit_valid(bit_valid),
    .last_bit(last_bit), .bit_ready(bit_ready), .char_out(char_out),
    .char_valid(char_valid), .char_ready(char_ready), .char_count(char_count),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every character handed over on the output handshake.
  always @(posedge clk) begin
    if (char_valid && char_ready) got_q.push_back(char_out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_tbl(input logic [31:0] ch, input logic [15:0] v,
                          input logic [15:0] m, input logic [2:0] uc);
    @(negedge clk);
    character = ch; encoded_value = v; encoded_mask = m; unique_count = uc;
    tbl_load = 1'b1;
    @(negedge clk);
    tbl_load = 1'b0;
    got_q.delete();
  endtask

  task automatic send_bit(input logic b, input logic lst);
    int t;
    t = 0;
    @(negedge clk);
    while (!bit_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bit_ready) chk("bit_ready_timeout", bit_ready, 1);
    bit_in = b; last_bit = lst; bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0; last_bit = 1'b0;
  endtask

  task automatic chk_chars(input string tag, input string exp);
    chk({tag, "_n"}, got_q.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      chk({tag, "_c"}, (i < got_q.size()) ? got_q[i] : 8'h00, exp[i]);
  endtask

  // a=0, n=10, u=11
  localparam logic [31:0] CH_ANU = {8'h00, "u", "n", "a"};
  localparam logic [15:0] V_ANU  = {4'h0, 4'b0011, 4'b0010, 4'b0000};
  localparam logic [15:0] M_ANU  = {4'h0, 4'b0011, 4'b0011, 4'b0001};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_char_count", char_count, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    // bit_valid in IDLE is ignored
    bit_valid = 1'b1; bit_in = 1'b1; last_bit = 1'b1;
    repeat (3) @(negedge clk);
    bit_valid = 1'b0; last_bit = 1'b0;
    chk("idle_bit_ready", bit_ready, 0);
    chk("idle_error", error, 0);
    chk("idle_done", done, 0);

    // Full stream a,n,u,a,n
    load_tbl(CH_ANU, V_ANU, M_ANU, 3'd3);
    chk("load_bit_ready", bit_ready, 1);
    send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 1);
    repeat (3) @(negedge clk);
    chk_chars("s1", "anuan");
    chk("s1_count", char_count, 5);
    chk("s1_done", done, 1);
    chk("s1_error", error, 0);
    chk("s1_bit_ready", bit_ready, 0);

    // Backpressure: output held, no bits consumed
    load_tbl(CH_ANU, V_ANU, M_ANU, 3'd3);
    char_ready = 1'b0;
    send_bit(0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", char_valid, 1);
      chk("bp_char", char_out, "a");
      chk("bp_bit_ready", bit_ready, 0);
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    chk("bp_count_held", char_count, 0);
    char_ready = 1'b1;
    @(negedge clk);
    chk("bp_count", char_count, 1);
    chk("bp_valid_drop", char_valid, 0);
    chk("bp_bit_ready", bit_ready, 1);
    chk_chars("bp", "a");

    // Invalid code 11 with table a=0, n=10
    load_tbl({16'h0, "n", "a"}, {8'h0, 4'b0010, 4'b0000}, {8'h0, 4'b0011, 4'b0001}, 3'd2);
    send_bit(1, 0);
    chk("inv_err_early", error, 0);
    send_bit(1, 0);
    chk("inv_error", error, 1);
    chk("inv_bit_ready", bit_ready, 0);
    chk("inv_valid", char_valid, 0);
    repeat (3) @(negedge clk);
    chk("inv_sticky", error, 1);
    chk("inv_count", char_count, 0);

    // Truncated code: 0 then 1 with last_bit
    load_tbl({16'h0, "n", "a"}, {8'h0, 4'b0010, 4'b0000}, {8'h0, 4'b0011, 4'b0001}, 3'd2);
    chk("trunc_clear", error, 0);
    send_bit(0, 0); send_bit(1, 1);
    repeat (2) @(negedge clk);
    chk_chars("trunc", "a");
    chk("trunc_error", error, 1);
    chk("trunc_done", done, 0);
    chk("trunc_count", char_count, 1);

    // Single-entry table: every bit is character[0]
    load_tbl({"q", "q", "q", "a"}, 16'h0, 16'h0001, 3'd1);
    send_bit(0, 0); send_bit(1, 0); send_bit(0, 1);
    repeat (3) @(negedge clk);
    chk_chars("one", "aaa");
    chk("one_done", done, 1);
    chk("one_count", char_count, 3);

    // Mask 0 never matches; lowest index wins among duplicates
    load_tbl({"y", "x", "b", "p"}, {4'b0001, 4'b0001, 4'b0000, 4'b0000},
             {4'b0001, 4'b0001, 4'b0001, 4'b0000}, 3'd4);
    send_bit(0, 0); send_bit(1, 1);
    repeat (3) @(negedge clk);
    chk_chars("prio", "bx");
    chk("prio_done", done, 1);

    // Empty table: any bit errors
    load_tbl(CH_ANU, V_ANU, M_ANU, 3'd0);
    send_bit(0, 0);
    chk("empty_error", error, 1);
    chk("empty_count", char_count, 0);

    // Count limit: 11th character errors, count stays at 10
    load_tbl({"q", "q", "q", "z"}, 16'h0, 16'h0001, 3'd1);
    for (int i = 0; i < 11; i++) send_bit(i[0], 0);
    repeat (2) @(negedge clk);
    chk("sat_error", error, 1);
    chk("sat_count", char_count, 10);
    chk("sat_n", got_q.size(), 10);

    // Reset in EMIT
    load_tbl(CH_ANU, V_ANU, M_ANU, 3'd3);
    char_ready = 1'b0;
    send_bit(0, 0);
    chk("remit_valid_pre", char_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("remit_valid", char_valid, 0);
    chk("remit_char_out", char_out, 0);
    chk("remit_bit_ready", bit_ready, 0);
    chk("remit_count", char_count, 0);
    char_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("remit_idle", bit_ready, 0);

    // Reset beats tbl_load
    character = CH_ANU; encoded_value = V_ANU; encoded_mask = M_ANU; unique_count = 3'd3;
    reset = 1'b1; tbl_load = 1'b1;
    @(negedge clk);
    reset = 1'b0; tbl_load = 1'b0;
    chk("rprio_bit_ready", bit_ready, 0);
    load_tbl(CH_ANU, V_ANU, M_ANU, 3'd3);
    chk("rprio_reload", bit_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
